v_pipe_query_mc: RTL and testbench
==================================

// Module: v_pipe_query_mc
// PURPOSE
//  Multi-channel successor to the single-port list query pipeline.
//  - Arbitrates CH_N query requesters onto the one state-table read port.
//  - Detects hazards against UPD_STAGES in-flight update stages.
//  - Optionally stalls a busy query up to RETRY_N cycles before returning BUSY.
//  - Returns key/volume/listsize/error on a registered per-channel response bus.
// PARAMETERS
//  CH_N        2   number of query channels (1..8)
//  ENTRIES_N   16  levels per list (state.vld/key/volume vector length)
//  UPD_STAGES  4   update-pipeline stages checked for hazard
//  RETRY_N     3   max stall cycles on busy before BUSY error; 0 = error at once
//  ID_W 8, KEY_W 32, VOL_W 32, LSZ_W 5  field widths; LVL_W = $clog2(ENTRIES_N)
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  asynchronous reset, active-low
//  i_req_vld      in   CH_N               per-channel query valid
//  i_req_id       in   CH_N*ID_W          per-channel product id
//  i_req_level    in   CH_N*LVL_W         per-channel level
//  o_req_rdy      out  CH_N               query accepted this cycle (one-hot or 0)
//  o_rsp_vld      out  CH_N               response valid, one-hot or 0, no backpressure
//  o_rsp_key      out  KEY_W              key of selected level
//  o_rsp_volume   out  VOL_W              volume of selected level
//  o_rsp_listsize out  LSZ_W              list occupancy from state
//  o_rsp_err      out  2                  0 OK, 1 INVALID, 2 BUSY
//  o_state_ren    out  1                  state-table read enable
//  o_state_raddr  out  ID_W               state-table read address
//  i_state_rdata  in   state_t            read data, valid one cycle after ren
//  i_upd_vld      in   UPD_STAGES         update stage valid (flopped upstream)
//  i_upd_id       in   UPD_STAGES*ID_W    update stage product id
// BEHAVIOUR
//  - Reset: o_rsp_vld=0, key/volume/listsize/err=0, RR pointer=0, retry cnts=0, S1 valid=0.
//  - busy[c] = OR over s of (i_upd_vld[s] & i_upd_id[s]==i_req_id[c]); combinational in S0.
//  - Per-channel cnt[c] (width clog2(RETRY_N+1)):
//      increments, saturating at RETRY_N, each cycle vld & busy & not accepted;
//      clears on accept or when vld drops.
//  - eligible[c] = i_req_vld[c] & (!busy[c] | cnt[c]==RETRY_N).
//  - S0 arbitration: round-robin over eligible, starting at ptr.
//      Winner g: o_req_rdy[g]=1.
//      Read issued (o_state_ren=1, raddr=id[g]) only if !busy[g].
//      Pointer moves to g+1 mod CH_N after a grant; it does not move when nothing is granted.
//  - Accept captures into S1: ch, level (decoded one-hot), busy flag.
//  - S1: if busy flag, err=BUSY and key/volume/listsize=0.
//      Else if (dec & rdata.vld)==0, err=INVALID; key/volume/listsize still driven from rdata.
//      Else err=OK; key/volume muxed by decoded level; listsize=rdata.listsize.
//  - S2: S1 result flopped to outputs; o_rsp_vld[ch]=1 for exactly one cycle.
//  - Latency: accept at cycle T -> response at T+2. Throughput 1 query/cycle total.
//  - Requester must hold vld/id/level stable until rdy. Changing id while waiting
//    has no defined effect on cnt (cnt is not reset by an id change).
//  - Update arriving in the same cycle as the S0 check counts as busy.
//    An update arriving after accept is not re-checked; there is no forwarding.
//  - Level >= ENTRIES_N decodes to 0 and returns INVALID.
//  - Async reset mid-flight drops S1/S2 contents. No response is produced for
//    queries accepted before reset.
//  - CH_N=1, RETRY_N=0: identical results to the legacy single-port query
//    pipeline, plus one extra output register stage.
// TESTING
//  1. Ch0 id=5 lvl=3, vld bit3=1, key[3]=0xABCD:
//     rdy0 at T, rsp_vld=01 at T+2, key=0xABCD, err=OK.
//  2. Ch0 and ch1 valid every cycle with no hazards:
//     grants alternate 0,1,0,1; responses alternate; no lost or duplicated responses.
//  3. RETRY_N=3, ch0 id=7 with upd stage2 id=7 held busy:
//     rdy0 on 4th cycle, err=BUSY, o_state_ren=0 on that cycle.
//  4. Same as 3, but busy clears after 2 cycles:
//     accepted on cycle 3, err=OK with RAM data.
//  5. Level=9 where vld bit9=0:
//     err=INVALID, listsize = rdata.listsize.
//  6. Assert rst_n=0 the cycle after accept:
//     no rsp_vld after release; ptr=0 and cnt=0 after release.

Source files
------------

// File: rtl/v_pipe_query_mc.sv
// Multi-channel state-table query pipeline: round-robin arbitration with update-hazard
// stall/retry (S0), table read and level select (S1), registered per-channel response (S2).
module v_pipe_query_mc #(
    parameter int CH_N       = 2,
    parameter int ENTRIES_N  = 16,
    parameter int UPD_STAGES = 4,
    parameter int RETRY_N    = 3,
    parameter int ID_W       = 8,
    parameter int KEY_W      = 32,
    parameter int VOL_W      = 32,
    parameter int LSZ_W      = 5,
    parameter int LVL_W      = $clog2(ENTRIES_N),
    parameter int STATE_W    = LSZ_W + ENTRIES_N * (VOL_W + KEY_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CH_N-1:0]            i_req_vld,
    input  logic [CH_N*ID_W-1:0]       i_req_id,
    input  logic [CH_N*LVL_W-1:0]      i_req_level,
    output logic [CH_N-1:0]            o_req_rdy,
    output logic [CH_N-1:0]            o_rsp_vld,
    output logic [KEY_W-1:0]           o_rsp_key,
    output logic [VOL_W-1:0]           o_rsp_volume,
    output logic [LSZ_W-1:0]           o_rsp_listsize,
    output logic [1:0]                 o_rsp_err,
    output logic                       o_state_ren,
    output logic [ID_W-1:0]            o_state_raddr,
    input  logic [STATE_W-1:0]         i_state_rdata,
    input  logic [UPD_STAGES-1:0]      i_upd_vld,
    input  logic [UPD_STAGES*ID_W-1:0] i_upd_id
);

    // Handshake: a query is transferred when i_req_vld[c] and o_req_rdy[c] are both high in
    // the same cycle; the requester holds id/level until then. Responses have no backpressure.

    localparam int CNT_W = (RETRY_N > 0) ? $clog2(RETRY_N + 1) : 1;
    localparam int CH_W  = (CH_N > 1) ? $clog2(CH_N) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RETRY_N);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_INVALID = 2'd1;
    localparam logic [1:0] ERR_BUSY    = 2'd2;

    typedef struct packed {
        logic [LSZ_W-1:0]                  listsize;
        logic [ENTRIES_N-1:0][VOL_W-1:0]   volume;
        logic [ENTRIES_N-1:0][KEY_W-1:0]   key;
        logic [ENTRIES_N-1:0]              vld;
    } state_t;

    state_t rdata;
    assign rdata = i_state_rdata;

    logic [CH_W-1:0]             ptr_q, ptr_d;
    logic [CH_N-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    logic                        s1_vld_q, s1_vld_d;
    logic [CH_W-1:0]             s1_ch_q, s1_ch_d;
    logic [ENTRIES_N-1:0]        s1_dec_q, s1_dec_d;
    logic                        s1_busy_q, s1_busy_d;

    logic [CH_N-1:0]             rsp_vld_q, rsp_vld_d;
    logic [KEY_W-1:0]            rsp_key_q, rsp_key_d;
    logic [VOL_W-1:0]            rsp_vol_q, rsp_vol_d;
    logic [LSZ_W-1:0]            rsp_lsz_q, rsp_lsz_d;
    logic [1:0]                  rsp_err_q, rsp_err_d;

    logic [CH_N-1:0]             busy, elig, rdy;
    logic                        grant_vld, grant_busy;
    logic [CH_W-1:0]             grant_ch;
    logic [ID_W-1:0]             raddr;
    logic [LVL_W-1:0]            grant_lvl;
    logic [ENTRIES_N-1:0]        dec;
    logic [KEY_W-1:0]            key_sel;
    logic [VOL_W-1:0]            vol_sel;
    int                          idx;

    // S0: hazard check, retry counters, round-robin grant and table read issue.
    always_comb begin
        busy       = '0;
        elig       = '0;
        rdy        = '0;
        grant_vld  = 1'b0;
        grant_busy = 1'b0;
        grant_ch   = '0;
        raddr      = '0;
        grant_lvl  = '0;
        dec        = '0;
        idx        = 0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;

        for (int c = 0; c < CH_N; c++) begin
            for (int s = 0; s < UPD_STAGES; s++) begin
                if (i_upd_vld[s] && (i_upd_id[s*ID_W +: ID_W] == i_req_id[c*ID_W +: ID_W]))
                    busy[c] = 1'b1;
            end
            elig[c] = i_req_vld[c] && (!busy[c] || (cnt_q[c] == CNT_MAX));
        end

        for (int i = 0; i < CH_N; i++) begin
            idx = (int'(ptr_q) + i) % CH_N;
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end

        for (int c = 0; c < CH_N; c++) begin
            if (grant_vld && (int'(grant_ch) == c)) begin
                rdy[c]     = 1'b1;
                grant_busy = busy[c];
                raddr      = i_req_id[c*ID_W +: ID_W];
                grant_lvl  = i_req_level[c*LVL_W +: LVL_W];
            end
        end

        // Levels outside the list match no entry and decode to all-zero.
        for (int e = 0; e < ENTRIES_N; e++)
            dec[e] = (grant_lvl == LVL_W'(e));

        if (grant_vld)
            ptr_d = (int'(grant_ch) == CH_N - 1) ? '0 : grant_ch + 1'b1;

        for (int c = 0; c < CH_N; c++) begin
            if (!i_req_vld[c] || rdy[c])
                cnt_d[c] = '0;
            else if (busy[c] && (cnt_q[c] != CNT_MAX))
                cnt_d[c] = cnt_q[c] + 1'b1;
        end
    end

    assign o_req_rdy     = rdy;
    assign o_state_ren   = grant_vld && !grant_busy;
    assign o_state_raddr = raddr;

    assign s1_vld_d  = grant_vld;
    assign s1_ch_d   = grant_ch;
    assign s1_dec_d  = dec;
    assign s1_busy_d = grant_busy;

    // S1: read data arrives this cycle; select the level and classify the result.
    always_comb begin
        key_sel   = '0;
        vol_sel   = '0;
        rsp_vld_d = '0;
        rsp_key_d = rsp_key_q;
        rsp_vol_d = rsp_vol_q;
        rsp_lsz_d = rsp_lsz_q;
        rsp_err_d = rsp_err_q;

        for (int e = 0; e < ENTRIES_N; e++) begin
            if (s1_dec_q[e]) begin
                key_sel = key_sel | rdata.key[e];
                vol_sel = vol_sel | rdata.volume[e];
            end
        end

        if (s1_vld_q) begin
            rsp_vld_d[s1_ch_q] = 1'b1;
            if (s1_busy_q) begin
                rsp_err_d = ERR_BUSY;
                rsp_key_d = '0;
                rsp_vol_d = '0;
                rsp_lsz_d = '0;
            end else begin
                rsp_err_d = ((s1_dec_q & rdata.vld) == '0) ? ERR_INVALID : ERR_OK;
                rsp_key_d = key_sel;
                rsp_vol_d = vol_sel;
                rsp_lsz_d = rdata.listsize;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_dec_q  <= '0;
            s1_busy_q <= 1'b0;
            rsp_vld_q <= '0;
            rsp_key_q <= '0;
            rsp_vol_q <= '0;
            rsp_lsz_q <= '0;
            rsp_err_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_ch_q   <= s1_ch_d;
            s1_dec_q  <= s1_dec_d;
            s1_busy_q <= s1_busy_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_key_q <= rsp_key_d;
            rsp_vol_q <= rsp_vol_d;
            rsp_lsz_q <= rsp_lsz_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign o_rsp_vld      = rsp_vld_q;
    assign o_rsp_key      = rsp_key_q;
    assign o_rsp_volume   = rsp_vol_q;
    assign o_rsp_listsize = rsp_lsz_q;
    assign o_rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_v_pipe_query_mc.sv
// Bench for v_pipe_query_mc: directed scenarios plus randomized traffic, with responses
// checked against a table-based reference model through an expected queue.
module tb_v_pipe_query_mc;

    localparam int CH_N  = 2;
    localparam int E     = 16;
    localparam int US    = 4;
    localparam int RN    = 3;
    localparam int ID_W  = 8;
    localparam int KEY_W = 32;
    localparam int VOL_W = 32;
    localparam int LSZ_W = 5;
    localparam int LVL_W = 4;
    localparam int EXP_W = CH_N + KEY_W + VOL_W + LSZ_W + 2;

    typedef struct packed {
        logic [LSZ_W-1:0]          listsize;
        logic [E-1:0][VOL_W-1:0]   volume;
        logic [E-1:0][KEY_W-1:0]   key;
        logic [E-1:0]              vld;
    } state_t;

    logic clk, rst_n;
    logic [CH_N-1:0]       req_vld;
    logic [ID_W-1:0]       req_id [CH_N];
    logic [LVL_W-1:0]      req_lvl [CH_N];
    logic [US-1:0]         upd_vld;
    logic [ID_W-1:0]       upd_id [US];

    logic [CH_N*ID_W-1:0]  i_req_id_f;
    logic [CH_N*LVL_W-1:0] i_req_lvl_f;
    logic [US*ID_W-1:0]    i_upd_id_f;

    logic [CH_N-1:0]  o_req_rdy, o_rsp_vld;
    logic [KEY_W-1:0] o_rsp_key;
    logic [VOL_W-1:0] o_rsp_volume;
    logic [LSZ_W-1:0] o_rsp_listsize;
    logic [1:0]       o_rsp_err;
    logic             o_state_ren;
    logic [ID_W-1:0]  o_state_raddr;
    state_t           rdata;

    state_t tbl [256];
    logic [EXP_W-1:0] exp_q[$];
    int               exp_t_q[$];
    int total, bad, cyc;

    v_pipe_query_mc #(
        .CH_N(CH_N), .ENTRIES_N(E), .UPD_STAGES(US), .RETRY_N(RN), .ID_W(ID_W),
        .KEY_W(KEY_W), .VOL_W(VOL_W), .LSZ_W(LSZ_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_vld(req_vld), .i_req_id(i_req_id_f), .i_req_level(i_req_lvl_f),
        .o_req_rdy(o_req_rdy), .o_rsp_vld(o_rsp_vld), .o_rsp_key(o_rsp_key),
        .o_rsp_volume(o_rsp_volume), .o_rsp_listsize(o_rsp_listsize), .o_rsp_err(o_rsp_err),
        .o_state_ren(o_state_ren), .o_state_raddr(o_state_raddr), .i_state_rdata(rdata),
        .i_upd_vld(upd_vld), .i_upd_id(i_upd_id_f)
    );

    // Clock / reset-time bookkeeping
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        i_req_id_f  = '0;
        i_req_lvl_f = '0;
        i_upd_id_f  = '0;
        for (int c = 0; c < CH_N; c++) begin
            i_req_id_f[c*ID_W +: ID_W]    = req_id[c];
            i_req_lvl_f[c*LVL_W +: LVL_W] = req_lvl[c];
        end
        for (int s = 0; s < US; s++)
            i_upd_id_f[s*ID_W +: ID_W] = upd_id[s];
    end

    // State table: one-cycle read latency.
    always @(posedge clk) if (o_state_ren) rdata <= tbl[o_state_raddr];

    // Reference model
    function automatic logic model_busy(logic [ID_W-1:0] id);
        logic b = 1'b0;
        for (int s = 0; s < US; s++)
            if (upd_vld[s] && upd_id[s] == id) b = 1'b1;
        return b;
    endfunction

    function automatic logic [EXP_W-1:0] model_rsp(int ch, logic [ID_W-1:0] id,
                                                   logic [LVL_W-1:0] lvl, logic bz);
        logic [CH_N-1:0] oh;
        state_t st;
        oh = '0;
        oh[ch] = 1'b1;
        st = tbl[id];
        if (bz) return {oh, {KEY_W{1'b0}}, {VOL_W{1'b0}}, {LSZ_W{1'b0}}, 2'd2};
        if (int'(lvl) >= E) return {oh, {KEY_W{1'b0}}, {VOL_W{1'b0}}, st.listsize, 2'd1};
        return {oh, st.key[lvl], st.volume[lvl], st.listsize, st.vld[lvl] ? 2'd0 : 2'd1};
    endfunction

    task automatic push_exp(int ch, logic [ID_W-1:0] id, logic [LVL_W-1:0] lvl, logic bz);
        exp_q.push_back(model_rsp(ch, id, lvl, bz));
        exp_t_q.push_back(cyc + 2);
    endtask

    // Scoreboard: each expectation must appear exactly on its due cycle.
    always @(negedge clk) begin
        logic [EXP_W-1:0] obs, e;
        int t;
        if (rst_n) begin
            obs = {o_rsp_vld, o_rsp_key, o_rsp_volume, o_rsp_listsize, o_rsp_err};
            if (exp_q.size() > 0 && exp_t_q[0] <= cyc) begin
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL rsp cyc=%0d due=%0d: got %h want %h", cyc, t, obs, e);
                end
            end else if (o_rsp_vld !== '0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected cyc=%0d: got vld=%b want 00", cyc, o_rsp_vld);
            end
        end
    end

    task automatic idle(int n);
        req_vld = '0;
        upd_vld = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({o_rsp_vld, o_rsp_key, o_rsp_volume, o_rsp_listsize, o_rsp_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got vld=%b key=%h err=%0d want all 0",
                     o_rsp_vld, o_rsp_key, o_rsp_err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (o_req_rdy !== '0 || o_state_ren !== 1'b0 || o_rsp_vld !== '0) begin
            bad++;
            $display("FAIL reset_idle: got rdy=%b ren=%b vld=%b want 0", o_req_rdy, o_state_ren, o_rsp_vld);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req_vld = 2'b01;
        req_id[0] = 8'd5;
        req_lvl[0] = 4'd3;
        @(negedge clk);
        total++;
        if (o_req_rdy !== 2'b01 || o_state_ren !== 1'b1 || o_state_raddr !== 8'd5) begin
            bad++;
            $display("FAIL single_accept: got rdy=%b ren=%b raddr=%0d want 01 1 5",
                     o_req_rdy, o_state_ren, o_state_raddr);
        end
        exp_q.push_back({2'b01, 32'hABCD, tbl[5].volume[3], tbl[5].listsize, 2'd0});
        exp_t_q.push_back(cyc + 2);
        @(posedge clk);
        #1;
        idle(3);
    endtask

    task automatic test_back_to_back();
        int exp_g, g;
        exp_g = 1;
        req_vld = 2'b11;
        for (int c = 0; c < CH_N; c++) begin
            req_id[c] = 8'($urandom_range(0, 255));
            req_lvl[c] = 4'($urandom_range(0, 15));
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            total++;
            if (o_req_rdy !== (2'b01 << exp_g)) begin
                bad++;
                $display("FAIL b2b_grant n=%0d: got rdy=%b want ch%0d", n, o_req_rdy, exp_g);
            end
            g = -1;
            for (int c = 0; c < CH_N; c++) if (o_req_rdy[c]) g = c;
            if (g >= 0) begin
                push_exp(g, req_id[g], req_lvl[g], 1'b0);
                exp_g = 1 - g;
            end
            @(posedge clk);
            #1;
            if (g >= 0) begin
                req_id[g] = 8'($urandom_range(0, 255));
                req_lvl[g] = 4'($urandom_range(0, 15));
            end
        end
        idle(3);
    endtask

    task automatic test_busy_retry();
        int got;
        logic ren_at;
        got = 0;
        ren_at = 1'bx;
        req_vld = 2'b01;
        req_id[0] = 8'd7;
        req_lvl[0] = 4'd2;
        upd_vld = 4'b0100;
        upd_id[2] = 8'd7;
        for (int k = 1; k <= 8 && got == 0; k++) begin
            @(negedge clk);
            if (o_req_rdy[0]) begin
                got = k;
                ren_at = o_state_ren;
                push_exp(0, 8'd7, 4'd2, 1'b1);
            end
            @(posedge clk);
            #1;
        end
        idle(3);
        total++;
        if (got !== 4) begin
            bad++;
            $display("FAIL retry_cycle: got accept cycle %0d want 4", got);
        end
        total++;
        if (ren_at !== 1'b0) begin
            bad++;
            $display("FAIL retry_ren: got ren=%b want 0", ren_at);
        end
    endtask

    task automatic test_busy_clear();
        int got;
        logic ren_at;
        got = 0;
        ren_at = 1'bx;
        req_vld = 2'b01;
        req_id[0] = 8'd7;
        req_lvl[0] = 4'd2;
        upd_id[2] = 8'd7;
        for (int k = 1; k <= 8 && got == 0; k++) begin
            upd_vld = (k <= 2) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (o_req_rdy[0]) begin
                got = k;
                ren_at = o_state_ren;
                push_exp(0, 8'd7, 4'd2, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        idle(3);
        total++;
        if (got !== 3 || ren_at !== 1'b1) begin
            bad++;
            $display("FAIL clear_accept: got cycle %0d ren=%b want 3 1", got, ren_at);
        end
    endtask

    task automatic test_invalid();
        req_vld = 2'b10;
        req_id[1] = 8'd9;
        req_lvl[1] = 4'd9;
        @(negedge clk);
        total++;
        if (o_req_rdy !== 2'b10) begin
            bad++;
            $display("FAIL invalid_accept: got rdy=%b want 10", o_req_rdy);
        end else begin
            push_exp(1, 8'd9, 4'd9, 1'b0);
        end
        @(posedge clk);
        #1;
        idle(3);
    endtask

    task automatic test_reset_midflight();
        int got;
        // Counter state must not survive reset.
        req_vld = 2'b10;
        req_id[1] = 8'd12;
        req_lvl[1] = 4'd0;
        upd_vld = 4'b0001;
        upd_id[0] = 8'd12;
        @(negedge clk);
        total++;
        if (o_req_rdy !== 2'b00) begin
            bad++;
            $display("FAIL rst_pre_wait: got rdy=%b want 00", o_req_rdy);
        end
        @(posedge clk);
        #1;
        req_vld = 2'b11;
        req_id[0] = 8'd3;
        req_lvl[0] = 4'd1;
        @(negedge clk);
        total++;
        if (o_req_rdy !== 2'b01) begin
            bad++;
            $display("FAIL rst_pre_accept: got rdy=%b want 01", o_req_rdy);
        end
        @(posedge clk);
        #1;
        req_vld = 2'b10;
        rst_n = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got = 0;
        for (int k = 1; k <= 8 && got == 0; k++) begin
            @(negedge clk);
            if (o_req_rdy[1]) begin
                got = k;
                push_exp(1, 8'd12, 4'd0, 1'b1);
            end else begin
                total++;
                if (o_rsp_vld !== '0) begin
                    bad++;
                    $display("FAIL rst_drop k=%0d: got vld=%b want 00", k, o_rsp_vld);
                end
            end
            @(posedge clk);
            #1;
        end
        idle(3);
        total++;
        if (got !== 4) begin
            bad++;
            $display("FAIL rst_cnt: got accept cycle %0d want 4", got);
        end
        // Pointer must return to channel 0.
        req_vld = 2'b01;
        req_id[0] = 8'd3;
        @(negedge clk);
        if (o_req_rdy[0]) push_exp(0, req_id[0], req_lvl[0], 1'b0);
        @(posedge clk);
        #1;
        req_vld = 2'b00;
        rst_n = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_vld = 2'b11;
        req_id[1] = 8'd4;
        @(negedge clk);
        total++;
        if (o_req_rdy !== 2'b01) begin
            bad++;
            $display("FAIL rst_ptr: got rdy=%b want 01", o_req_rdy);
        end
        if (o_req_rdy[0]) push_exp(0, req_id[0], req_lvl[0], 1'b0);
        @(posedge clk);
        #1;
        req_vld = 2'b10;
        @(negedge clk);
        if (o_req_rdy[1]) push_exp(1, req_id[1], req_lvl[1], 1'b0);
        @(posedge clk);
        #1;
        idle(4);
    endtask

    task automatic test_random();
        logic [CH_N-1:0] pend, b, el;
        int cnt [CH_N];
        pend = '0;
        for (int c = 0; c < CH_N; c++) cnt[c] = 0;
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < CH_N; c++) begin
                if (!pend[c] && $urandom_range(0, 9) < 6) begin
                    pend[c] = 1'b1;
                    req_id[c] = 8'($urandom_range(0, 7));
                    req_lvl[c] = 4'($urandom_range(0, 15));
                end
            end
            req_vld = pend;
            for (int s = 0; s < US; s++) begin
                upd_vld[s] = ($urandom_range(0, 3) == 0);
                upd_id[s] = 8'($urandom_range(0, 7));
            end
            @(negedge clk);
            for (int c = 0; c < CH_N; c++) begin
                b[c] = model_busy(req_id[c]);
                el[c] = req_vld[c] && (!b[c] || cnt[c] == RN);
            end
            total++;
            if (!$onehot0(o_req_rdy) || (o_req_rdy & ~el) != '0 || ((el != '0) != (o_req_rdy != '0))
                || (o_req_rdy == '0 && o_state_ren !== 1'b0)) begin
                bad++;
                $display("FAIL rand_grant n=%0d: got rdy=%b ren=%b eligible=%b", n, o_req_rdy, o_state_ren, el);
            end
            for (int c = 0; c < CH_N; c++) begin
                if (o_req_rdy[c]) begin
                    total++;
                    if (o_state_ren !== !b[c] || (!b[c] && o_state_raddr !== req_id[c])) begin
                        bad++;
                        $display("FAIL rand_read n=%0d ch%0d: got ren=%b raddr=%0d want ren=%b raddr=%0d",
                                 n, c, o_state_ren, o_state_raddr, !b[c], req_id[c]);
                    end
                    push_exp(c, req_id[c], req_lvl[c], b[c]);
                    pend[c] = 1'b0;
                end
            end
            for (int c = 0; c < CH_N; c++) begin
                if (!req_vld[c] || o_req_rdy[c]) cnt[c] = 0;
                else if (b[c] && cnt[c] < RN) cnt[c]++;
            end
            @(posedge clk);
            #1;
        end
        idle(4);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        req_vld = '0;
        upd_vld = '0;
        for (int c = 0; c < CH_N; c++) begin
            req_id[c] = '0;
            req_lvl[c] = '0;
        end
        for (int s = 0; s < US; s++) upd_id[s] = '0;
        for (int i = 0; i < 256; i++) begin
            tbl[i].vld = 16'($urandom);
            for (int e = 0; e < E; e++) begin
                tbl[i].key[e] = $urandom;
                tbl[i].volume[e] = $urandom;
            end
            tbl[i].listsize = 5'($urandom_range(0, 31));
        end
        tbl[5].vld[3] = 1'b1;
        tbl[5].key[3] = 32'hABCD;
        tbl[7].vld[2] = 1'b1;
        tbl[9].vld[9] = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_busy_retry();
        test_busy_clear();
        test_invalid();
        test_reset_midflight();
        test_random();

        idle(4);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending responses want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
